// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, bit-period derivation, FSM states and parity.
package uart_pkg;

    localparam int DATA_BITS         = 7;
    localparam int DEF_CLK_PERIOD_NS = 60;
    localparam int DEF_BIT_PERIOD_NS = 104167;
    localparam logic LINE_IDLE       = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    function automatic int clksPerBit(input int clkPeriodNs, input int bitPeriodNs);
        return bitPeriodNs / clkPeriodNs;
    endfunction

    function automatic logic parityOf(input logic [DATA_BITS-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: flags the last cycle of each bit and is held at zero while cleared.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 1736
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic tick_o,
    output logic lastNext_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i || count_q == LAST) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o     = !clear_i && (count_q == LAST);
    // Lets the owner register a pulse that lands on the final cycle of a bit.
    assign lastNext_o = (count_d == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start, 7 data bits LSB first, even parity, stop; one-deep holding register.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLK_PERIOD_NS = DEF_CLK_PERIOD_NS,
    parameter int BIT_PERIOD_NS = DEF_BIT_PERIOD_NS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 corrupt_parity,
    output logic                 transmit_bit,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int CLKS_PER_BIT = clksPerBit(CLK_PERIOD_NS, BIT_PERIOD_NS);
    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    uart_state_e state_q, state_d;
    logic                 holdFull_q, holdFull_d;
    logic [DATA_BITS-1:0] holdData_q, holdData_d;
    logic                 holdCorrupt_q, holdCorrupt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic [2:0]           bitIdx_q, bitIdx_d;
    logic                 txBit_q, txBit_d;
    logic                 busy_q, busy_d;
    logic                 frameDone_q, frameDone_d;
    logic                 bitEnd;
    logic                 lastCycleNext;
    logic                 transfer;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_i      (clk),
        .rst_i      (rst),
        .clear_i    (state_q == IDLE),
        .tick_o     (bitEnd),
        .lastNext_o (lastCycleNext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            holdFull_q    <= 1'b0;
            holdData_q    <= '0;
            holdCorrupt_q <= 1'b0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            bitIdx_q      <= '0;
            txBit_q       <= LINE_IDLE;
            busy_q        <= 1'b0;
            frameDone_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            holdFull_q    <= holdFull_d;
            holdData_q    <= holdData_d;
            holdCorrupt_q <= holdCorrupt_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            bitIdx_q      <= bitIdx_d;
            txBit_q       <= txBit_d;
            busy_q        <= busy_d;
            frameDone_q   <= frameDone_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bitIdx_d      = bitIdx_q;
        shift_d       = shift_q;
        parity_d      = parity_q;
        holdFull_d    = holdFull_q;
        holdData_d    = holdData_q;
        holdCorrupt_d = holdCorrupt_q;
        transfer      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (holdFull_q) begin
                    transfer = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                if (bitEnd) begin
                    state_d  = DATA;
                    bitIdx_d = '0;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    if (bitIdx_q == LAST_IDX) begin
                        state_d = PARITY;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bitEnd) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // A waiting word starts its frame straight after this stop bit.
                if (bitEnd) begin
                    if (holdFull_q) begin
                        transfer = 1'b1;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (transfer) begin
            shift_d    = holdData_q;
            parity_d   = parityOf(holdData_q) ^ holdCorrupt_q;
            holdFull_d = 1'b0;
        end else if (in_valid && !holdFull_q) begin
            holdFull_d    = 1'b1;
            holdData_d    = in_data;
            holdCorrupt_d = corrupt_parity;
        end
    end

    // Outputs are decoded from next-state values so the registered line moves with the state.
    always_comb begin
        txBit_d = LINE_IDLE;
        unique case (state_d)
            IDLE:    txBit_d = LINE_IDLE;
            START:   txBit_d = ~LINE_IDLE;
            DATA:    txBit_d = shift_d[bitIdx_d];
            PARITY:  txBit_d = parity_d;
            STOP:    txBit_d = LINE_IDLE;
            default: txBit_d = LINE_IDLE;
        endcase
        busy_d      = (state_d != IDLE);
        frameDone_d = (state_d == STOP) && lastCycleNext;
    end

    assign in_ready     = !holdFull_q;
    assign transmit_bit = txBit_q;
    assign busy         = busy_q;
    assign frame_done   = frameDone_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at 10 clocks per bit; line patterns are hand-computed.
module tb_uart_transmitter;

    localparam int CPB          = 10;
    localparam int FRAME_CYCLES = 10 * CPB;

    // Patterns are {stop, parity, d6..d0, start}; bit k is the line level in bit slot k.
    localparam logic [9:0] P41  = 10'b1_0_1000001_0;
    localparam logic [9:0] P07  = 10'b1_1_0000111_0;
    localparam logic [9:0] P7F  = 10'b1_1_1111111_0;
    localparam logic [9:0] P00C = 10'b1_1_0000000_0;
    localparam logic [9:0] P55  = 10'b1_0_1010101_0;
    localparam logic [9:0] P2A  = 10'b1_1_0101010_0;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       corrupt_parity;
    logic       transmit_bit;
    logic       busy;
    logic       frame_done;

    int total = 0;
    int bad   = 0;

    always #30 clk = ~clk;

    uart_transmitter #(
        .CLK_PERIOD_NS(60),
        .BIT_PERIOD_NS(600)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .corrupt_parity (corrupt_parity),
        .transmit_bit   (transmit_bit),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [6:0] data, input logic valid, input logic corrupt);
        in_data        = data;
        in_valid       = valid;
        corrupt_parity = corrupt;
    endtask

    task automatic checkIdle(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            checkOutput($sformatf("%s_tx_%0d", name, i), 32'(transmit_bit), 32'd1);
            checkOutput($sformatf("%s_busy_%0d", name, i), 32'(busy), 32'd0);
            checkOutput($sformatf("%s_done_%0d", name, i), 32'(frame_done), 32'd0);
            checkOutput($sformatf("%s_ready_%0d", name, i), 32'(in_ready), 32'd1);
            waitCycle();
        end
    endtask

    // Checks frame cycles firstCycle..lastCycle, advancing one clock after each.
    task automatic checkFrame(input string name, input logic [9:0] pattern, input int firstCycle, input int lastCycle);
        for (int k = firstCycle; k <= lastCycle; k++) begin
            checkOutput($sformatf("%s_tx_c%0d", name, k), 32'(transmit_bit), 32'(pattern[(k - 1) / CPB]));
            checkOutput($sformatf("%s_busy_c%0d", name, k), 32'(busy), 32'd1);
            checkOutput($sformatf("%s_done_c%0d", name, k), 32'(frame_done), 32'(k == FRAME_CYCLES));
            waitCycle();
        end
    endtask

    // Accepts one word from idle and leaves the bench at frame cycle 1.
    task automatic sendWord(input string name, input logic [6:0] data, input logic corrupt);
        applyStimulus(data, 1'b1, corrupt);
        waitCycle();
        checkOutput({name, "_ready_held"}, 32'(in_ready), 32'd0);
        checkOutput({name, "_tx_e0"}, 32'(transmit_bit), 32'd1);
        checkOutput({name, "_busy_e0"}, 32'(busy), 32'd0);
        applyStimulus(data ^ 7'h7F, 1'b0, ~corrupt);
        waitCycle();
        checkOutput({name, "_ready_e1"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        applyStimulus(7'h00, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("rst_tx", 32'(transmit_bit), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(frame_done), 32'd0);
        checkOutput("rst_ready", 32'(in_ready), 32'd1);
        repeat (3) waitCycle();
        rst = 1'b0;

        $display("[TB] idle after reset");
        checkIdle("idle", 50);

        $display("[TB] single frame 0x41");
        sendWord("w41", 7'h41, 1'b0);
        checkFrame("f41", P41, 1, FRAME_CYCLES);
        checkIdle("after41", 5);

        $display("[TB] back-to-back 0x07 then 0x7F");
        sendWord("w07", 7'h07, 1'b0);
        checkFrame("f07", P07, 1, 29);
        applyStimulus(7'h7F, 1'b1, 1'b0);
        checkFrame("f07", P07, 30, 30);
        checkOutput("b2b_ready_pending", 32'(in_ready), 32'd0);
        applyStimulus(7'h00, 1'b0, 1'b0);
        checkFrame("f07", P07, 31, 99);
        checkOutput("b2b_ready_c100", 32'(in_ready), 32'd0);
        checkFrame("f07", P07, 100, 100);
        checkOutput("b2b_ready_xfer", 32'(in_ready), 32'd1);
        checkFrame("f7F", P7F, 1, FRAME_CYCLES);
        checkIdle("after7F", 3);

        $display("[TB] corrupted parity on 0x00");
        sendWord("w00", 7'h00, 1'b1);
        checkFrame("f00c", P00C, 1, FRAME_CYCLES);
        checkIdle("after00", 3);

        $display("[TB] reset in mid-frame with a word held");
        sendWord("w55", 7'h55, 1'b0);
        checkFrame("f55", P55, 1, 4);
        applyStimulus(7'h33, 1'b1, 1'b0);
        checkFrame("f55", P55, 5, 5);
        checkOutput("mid_ready_held", 32'(in_ready), 32'd0);
        applyStimulus(7'h00, 1'b0, 1'b0);
        checkFrame("f55", P55, 6, 34);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_tx", 32'(transmit_bit), 32'd1);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_done", 32'(frame_done), 32'd0);
        checkOutput("mid_rst_ready", 32'(in_ready), 32'd1);
        waitCycle();
        waitCycle();
        rst = 1'b0;
        checkIdle("postrst", 30);
        sendWord("w2A", 7'h2A, 1'b0);
        checkFrame("f2A", P2A, 1, FRAME_CYCLES);
        checkIdle("after2A", 3);

        $display("[TB] in_valid held high across three frames");
        applyStimulus(7'h55, 1'b1, 1'b0);
        waitCycle();
        checkOutput("hold_ready_e0", 32'(in_ready), 32'd0);
        checkOutput("hold_tx_e0", 32'(transmit_bit), 32'd1);
        applyStimulus(7'h2A, 1'b1, 1'b0);
        waitCycle();
        checkOutput("hold_ready_e1", 32'(in_ready), 32'd1);
        checkFrame("hA", P55, 1, 1);
        checkOutput("hold_ready_b", 32'(in_ready), 32'd0);
        applyStimulus(7'h55, 1'b1, 1'b0);
        checkFrame("hA", P55, 2, FRAME_CYCLES);
        checkOutput("hold_ready_xferb", 32'(in_ready), 32'd1);
        checkFrame("hB", P2A, 1, 1);
        checkOutput("hold_ready_c", 32'(in_ready), 32'd0);
        applyStimulus(7'h00, 1'b0, 1'b0);
        checkFrame("hB", P2A, 2, FRAME_CYCLES);
        checkFrame("hC", P55, 1, FRAME_CYCLES);
        checkIdle("afterhold", 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
Serialises 7-bit parallel words into UART frames on a single line: start bit, 7 data bits LSB first, even parity bit, stop bit.
Directly upstream of the receiver; its serial output drives the receiver's serial input, at the same bit period and frame format.
A one-deep holding register and a valid/ready input handshake allow back-to-back frames with no idle gap.

Parameters:
CLK_PERIOD_NS, 60, system clock period in ns
BIT_PERIOD_NS, 104167, serial bit period in ns (9600 baud)
CLKS_PER_BIT, BIT_PERIOD_NS/CLK_PERIOD_NS (integer division; 1736 at defaults), derived localparam, clocks per serial bit
DATA_BITS, 7, data bits per frame; fixed, not overridable

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
in_data  input  7  word to transmit
in_valid  input  1  in_data valid
in_ready  output  1  holding register empty; word accepted on a rising edge where in_valid and in_ready are both high
corrupt_parity  input  1  sampled with in_data; when 1, the frame's parity bit is inverted (test aid)
transmit_bit  output  1  serial line, idles high
busy  output  1  frame in progress (state != IDLE)
frame_done  output  1  one-cycle pulse on the last cycle of each stop bit

Behaviour:
- One clock; reset is asynchronous and active-high. All outputs are registered except in_ready, which is the inverse of hold_full.
- Reset values: transmit_bit=1, busy=0, frame_done=0, hold_full=0 (so in_ready=1), state=IDLE, bit and baud counters=0.
- Holding register: loads {corrupt_parity, in_data} on accept and sets hold_full. A clock edge that transfers the word to the shift register clears hold_full. Load and transfer cannot coincide, because in_ready=0 whenever hold_full=1.
- Parity bit = XOR of the 7 data bits, XOR corrupt_parity. When corrupt_parity=0, the count of ones across data and parity is even.
- Baud counter: counts 0..CLKS_PER_BIT-1 within each bit and wraps to 0 at bit end. Each bit is held exactly CLKS_PER_BIT cycles.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: transmit_bit=1. If hold_full, transfer to shift register, go to START, transmit_bit=0 from the next cycle.
  - START: transmit_bit=0; at bit end go to DATA with bit index 0.
  - DATA: transmit_bit=shift[index]; at bit end, index 0..5 increments, index 6 goes to PARITY.
  - PARITY: transmit_bit=parity; at bit end go to STOP.
  - STOP: transmit_bit=1. At bit end, frame_done pulses. If hold_full, transfer and go to START (no idle gap); otherwise go to IDLE.
- Latency: a word accepted at edge E0 while IDLE drives transmit_bit low after edge E1. in_ready rises after E1.
- Frame length is 10*CLKS_PER_BIT cycles (17360 at defaults).
- in_data changes after acceptance have no effect on the frame in flight.
- in_valid held high while in_ready=0: word stays pending, no loss, no duplicate.
- Reset asserted mid-frame: line returns high immediately and the frame is truncated. The pending held word is discarded.
- Reset deasserted: IDLE, no frame emitted until a new accept.

Decomposition:
- Shared package uart_pkg holds: DATA_BITS=7, default CLK_PERIOD_NS/BIT_PERIOD_NS, the CLKS_PER_BIT derivation, line idle level (1), the state enumeration, and the parity function (XOR reduce).
- Receiver and transmitter both use uart_pkg.
- One natural sub-module: uart_baud_tick, a counter that emits a bit-end tick every CLKS_PER_BIT cycles. It restarts when the FSM leaves IDLE and reuses the same reset.

Test Plan:
All scenarios use BIT_PERIOD_NS=600, CLK_PERIOD_NS=60, so CLKS_PER_BIT=10.
1. Reset, then idle 50 cycles -> transmit_bit=1, busy=0, in_ready=1, frame_done never pulses.
2. Send 7'h41, corrupt_parity=0 -> line sequence 0,1,0,0,0,0,0,1,0,1, each held 10 cycles; frame_done pulses once at cycle 100 of the frame; busy falls after.
3. Send 7'h07 then 7'h7F, presented while first is in flight -> parity bits 1 and 1; second start bit immediately follows first stop bit; in_ready low from second accept until its transfer.
4. Send 7'h00 with corrupt_parity=1 -> parity bit 1 (odd ones); a receiver on the line flags broken.
5. Assert rst at cycle 35 of a 7'h55 frame -> transmit_bit=1 within the same cycle, busy=0, held word dropped; after release, a new 7'h2A frame is correct.
6. Hold in_valid high with alternating in_data for 3 frames -> exactly 3 accepts, frames carry the accepted words in order, no duplicates.
